// File: rtl/reduce_gate_sweeper.sv
// rtl/reduce_gate_sweeper.sv - WIDTH-input AND/OR/XOR/NAND gate with truth-table sweep sequencer
// Define SWEEP_GRAY_EN to walk the vectors in Gray-code order instead of binary ascending.
module reduce_gate_sweeper #(
  parameter int WIDTH       = 4,
  parameter int STEP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] vec,
  output logic             s,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   ones_cnt
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0]  DWELL_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [WIDTH:0] IDX_LAST   = (WIDTH+1)'((1 << WIDTH) - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    dwell_q;
  logic [WIDTH:0]   idx_q;
  logic [1:0]       mode_q;
  logic             last_q;

  logic             tick, emit, is_last, s_cur;
  logic [CW-1:0]    phase;
  logic [WIDTH:0]   idx_cur, ones_base;
  logic [1:0]       mode_cur;
  logic [WIDTH-1:0] vec_cur;

  // The start edge itself counts as the first dwell tick, so with a dwell of
  // one cycle vector 0 is captured on that same edge using the live mode input.
  always_comb begin
    state_d   = state_q;
    tick      = 1'b0;
    phase     = dwell_q;
    idx_cur   = idx_q;
    mode_cur  = mode_q;
    ones_base = ones_cnt;
    case (state_q)
      IDLE: begin
        phase     = '0;
        idx_cur   = '0;
        mode_cur  = mode;
        ones_base = '0;
        if (start) begin
          tick    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_q) state_d = DONE;
        else        tick    = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    emit    = tick && (phase == DWELL_LAST);
    is_last = (idx_cur == IDX_LAST);
  end

`ifdef SWEEP_GRAY_EN
  assign vec_cur = idx_cur[WIDTH-1:0] ^ (idx_cur[WIDTH-1:0] >> 1);
`else
  assign vec_cur = idx_cur[WIDTH-1:0];
`endif

  always_comb begin
    s_cur = 1'b0;
    case (mode_cur)
      2'b00:   s_cur = &vec_cur;
      2'b01:   s_cur = |vec_cur;
      2'b10:   s_cur = ^vec_cur;
      default: s_cur = ~&vec_cur;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dwell_q  <= '0;
      idx_q    <= '0;
      mode_q   <= 2'b00;
      last_q   <= 1'b0;
      vec      <= '0;
      s        <= 1'b0;
      valid    <= 1'b0;
      ones_cnt <= '0;
    end else begin
      valid <= emit;
      if (state_q == IDLE && start) begin
        mode_q   <= mode;
        last_q   <= 1'b0;
        ones_cnt <= '0;
      end
      if (tick) begin
        dwell_q <= emit ? '0 : phase + CW'(1);
        idx_q   <= emit ? idx_cur + (WIDTH+1)'(1) : idx_cur;
      end
      if (emit) begin
        vec      <= vec_cur;
        s        <= s_cur;
        last_q   <= is_last;
        ones_cnt <= ones_base + {{WIDTH{1'b0}}, s_cur};
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_reduce_gate_sweeper.sv
// tb/tb_reduce_gate_sweeper.sv - timing/arithmetic model plus directed sweeps for reduce_gate_sweeper
module tb_reduce_gate_sweeper;

  localparam int WA = 4, SA = 1;
  localparam int WB = 3, SB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n_a, start_a, s_a, valid_a, busy_a, done_a;
  logic [1:0]    mode_a;
  logic [WA-1:0] vec_a;
  logic [WA:0]   ones_a;
  logic          rst_n_b, start_b, s_b, valid_b, busy_b, done_b;
  logic [1:0]    mode_b;
  logic [WB-1:0] vec_b;
  logic [WB:0]   ones_b;

  reduce_gate_sweeper #(.WIDTH(WA), .STEP_CYCLES(SA)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .mode(mode_a), .vec(vec_a), .s(s_a),
    .valid(valid_a), .busy(busy_a), .done(done_a), .ones_cnt(ones_a));

  reduce_gate_sweeper #(.WIDTH(WB), .STEP_CYCLES(SB)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .mode(mode_b), .vec(vec_b), .s(s_b),
    .valid(valid_b), .busy(busy_b), .done(done_b), .ones_cnt(ones_b));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Model: schedule derived from the start edge, e = edges elapsed since it.
  typedef struct {
    bit active;
    int t0, mode, vec, s, valid, busy, done, ones;
  } mst_t;
  mst_t m[2];

  function automatic int fgate(input int md, input int v, input int w);
    int pc;
    pc = $countones(v);
    case (md)
      0:       return (pc == w) ? 1 : 0;
      1:       return (pc != 0) ? 1 : 0;
      2:       return pc % 2;
      default: return (pc == w) ? 0 : 1;
    endcase
  endfunction

  function automatic int order(input int k);
`ifdef SWEEP_GRAY_EN
    return k ^ (k >> 1);
`else
    return k;
`endif
  endfunction

  task automatic model_step(input int i, input int w, input int step,
                            input logic rst, input logic st, input logic [1:0] md);
    int e, n, k;
    n = 1 << w;
    if (!rst) begin
      m[i].active = 0; m[i].t0 = 0; m[i].mode = 0; m[i].vec = 0; m[i].s = 0;
      m[i].valid = 0; m[i].busy = 0; m[i].done = 0; m[i].ones = 0;
    end else begin
      m[i].valid = 0;
      m[i].done  = 0;
      if (!m[i].active && st) begin
        m[i].active = 1; m[i].t0 = cyc; m[i].mode = int'(md); m[i].ones = 0;
      end
      if (m[i].active) begin
        e = cyc - m[i].t0;
        if (e == step * n + 1) begin
          m[i].active = 0;
        end else if (e == step * n) begin
          m[i].busy = 0;
          m[i].done = 1;
        end else begin
          m[i].busy = 1;
          if ((e + 1) % step == 0) begin
            k = (e + 1) / step - 1;
            m[i].vec   = order(k);
            m[i].s     = fgate(m[i].mode, m[i].vec, w);
            m[i].ones += m[i].s;
            m[i].valid = 1;
          end
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, WA, SA, rst_n_a, start_a, mode_a);
    model_step(1, WB, SB, rst_n_b, start_b, mode_b);
    cyc++;
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("a.vec",   32'(vec_a),   m[0].vec);
      chk("a.s",     32'(s_a),     m[0].s);
      chk("a.valid", 32'(valid_a), m[0].valid);
      chk("a.busy",  32'(busy_a),  m[0].busy);
      chk("a.done",  32'(done_a),  m[0].done);
      chk("a.ones",  32'(ones_a),  m[0].ones);
      chk("b.vec",   32'(vec_b),   m[1].vec);
      chk("b.s",     32'(s_b),     m[1].s);
      chk("b.valid", 32'(valid_b), m[1].valid);
      chk("b.busy",  32'(busy_b),  m[1].busy);
      chk("b.done",  32'(done_b),  m[1].done);
      chk("b.ones",  32'(ones_b),  m[1].ones);
    end
  end

  int q_vec[$];
  int q_s[$];
  int s_by_vec[256];

  // Starts a sweep, flips mode right after the start edge, optionally pokes
  // start+OR after the disturb_at-th valid, and records what comes out.
  task automatic sweep(input int sel, input logic [1:0] md, input int disturb_at,
                       output int nv, output int first_v, output int gap_bad, output int done_at);
    int step, last_t, dist_t, vv;
    logic v, d, sv;
    step = sel ? SB : SA;
    nv = 0; first_v = -1; gap_bad = 0; done_at = -1; last_t = 0; dist_t = -1;
    q_vec.delete(); q_s.delete();
    for (int i = 0; i < 256; i++) s_by_vec[i] = -1;
    if (sel != 0) begin start_b = 1'b1; mode_b = md; end
    else          begin start_a = 1'b1; mode_a = md; end
    @(negedge clk);
    if (sel != 0) begin start_b = 1'b0; mode_b = ~md; end
    else          begin start_a = 1'b0; mode_a = ~md; end
    for (int t = 1; t <= 300; t++) begin
      v  = (sel != 0) ? valid_b : valid_a;
      d  = (sel != 0) ? done_b : done_a;
      sv = (sel != 0) ? s_b : s_a;
      vv = (sel != 0) ? int'(vec_b) : int'(vec_a);
      if (dist_t > 0 && t == dist_t + 2) begin start_a = 1'b0; start_b = 1'b0; end
      if (v) begin
        if (nv == 0) first_v = t;
        else if (t - last_t != step) gap_bad++;
        last_t = t;
        q_vec.push_back(vv);
        q_s.push_back(int'(sv));
        s_by_vec[vv & 255] = int'(sv);
        nv++;
        if (nv == disturb_at) begin
          dist_t = t;
          if (sel != 0) begin start_b = 1'b1; mode_b = 2'b01; end
          else          begin start_a = 1'b1; mode_a = 2'b01; end
        end
      end
      if (d) begin
        done_at = t;
        break;
      end
      @(negedge clk);
    end
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  int gray3[8] = '{0, 1, 3, 2, 6, 7, 5, 4};

  initial begin
    int nv, fv, gb, da, sum, cnt, dn;
    rst_n_a = 1'b0; start_a = 1'b1; mode_a = 2'b00;
    rst_n_b = 1'b0; start_b = 1'b1; mode_b = 2'b00;

    repeat (2) begin
      @(negedge clk);
      chk("rst.busy", 32'(busy_a), 0);
      chk("rst.vec",  32'(vec_a), 0);
      chk("rst.ones", 32'(ones_a), 0);
      chk("rst.done", 32'(done_b), 0);
    end
    start_a = 1'b0; start_b = 1'b0;
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    @(negedge clk);

    sweep(0, 2'b00, 0, nv, fv, gb, da);
    chk("and.nvalid", nv, 16);
    chk("and.first", fv, 1);
    chk("and.gap", gb, 0);
    chk("and.done_at", da, 17);
    chk("and.ones", 32'(ones_a), 1);
    chk("and.s_at_1111", s_by_vec[15], 1);
    sum = 0;
    foreach (q_s[k]) sum += q_s[k];
    chk("and.sum_s", sum, 1);
`ifndef SWEEP_GRAY_EN
    foreach (q_vec[k]) chk("and.vec_order", q_vec[k], k);
`endif

    sweep(0, 2'b10, 0, nv, fv, gb, da);
    chk("xor.ones", 32'(ones_a), 8);
    chk("xor.s_at_0111", s_by_vec[7], 1);
    sweep(0, 2'b11, 0, nv, fv, gb, da);
    chk("nand.ones", 32'(ones_a), 15);
    sweep(0, 2'b01, 0, nv, fv, gb, da);
    chk("or.ones", 32'(ones_a), 15);
    chk("or.s_at_0", s_by_vec[0], 0);

    sweep(1, 2'b00, 3, nv, fv, gb, da);
    chk("step3.first", fv, 3);
    chk("step3.gap", gb, 0);
    chk("step3.nvalid", nv, 8);
    chk("step3.done_at", da, 25);
    chk("step3.ones", 32'(ones_b), 1);
`ifdef SWEEP_GRAY_EN
    foreach (q_vec[k]) chk("gray.vec", q_vec[k], gray3[k]);
    for (int k = 1; k < q_vec.size(); k++)
      chk("gray.onebit", $countones(q_vec[k] ^ q_vec[k-1]), 1);
`else
    foreach (q_vec[k]) chk("step3.vec_order", q_vec[k], k);
`endif
    sweep(1, 2'b10, 0, nv, fv, gb, da);
    chk("step3.xor_ones", 32'(ones_b), 4);

    start_a = 1'b1; mode_a = 2'b00;
    @(negedge clk);
    start_a = 1'b0;
    cnt = 0;
    for (int t = 0; t < 50 && cnt < 7; t++) begin
      if (valid_a) cnt++;
      if (cnt < 7) @(negedge clk);
    end
    chk("rst_mid.valids_seen", cnt, 7);
    rst_n_a = 1'b0;
    @(negedge clk);
    chk("rst_mid.vec", 32'(vec_a), 0);
    chk("rst_mid.s", 32'(s_a), 0);
    chk("rst_mid.valid", 32'(valid_a), 0);
    chk("rst_mid.busy", 32'(busy_a), 0);
    chk("rst_mid.done", 32'(done_a), 0);
    chk("rst_mid.ones", 32'(ones_a), 0);
    rst_n_a = 1'b1;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_a || busy_a) dn++;
    end
    chk("rst_mid.no_done", dn, 0);
    sweep(0, 2'b01, 0, nv, fv, gb, da);
    chk("rst_mid.restart_vec0", q_vec.size() > 0 ? q_vec[0] : -1, 0);
    chk("rst_mid.restart_nvalid", nv, 16);
    chk("rst_mid.restart_ones", 32'(ones_a), 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
